multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter OPW, default 6: opcode width; opcodes below zero-extended to OPW.
REQ-002 SHALL have parameter WAIT_MAX, default 15: max mem_ready wait cycles per memory state, 1..255.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports op  in  OPW  opcode; mem_ready  in  1  memory completion.
REQ-006 SHALL have ports mem_req, iord, irwrite, pcwrite, branch, memwrite  out  1  memory/PC controls.
REQ-007 SHALL have ports regdst, regwrite, memtoreg, alusrca, byte_enable, res_zeroextimm  out  1  datapath controls.
REQ-008 SHALL have ports alusrcb, pcsrc, aluop  out  2 each  mux/ALU selects.
REQ-009 SHALL have ports err  out  1  sticky fault; state_o  out  4  current state code.

Function
REQ-010 SHALL implement a Moore FSM: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, LIWB, ERR.
REQ-011 FETCH SHALL drive mem_req=1, iord=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=mem_ready; advance to DECODE only when mem_ready=1.
REQ-012 DECODE SHALL drive alusrcb=11, aluop=00 and dispatch: 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP, 010001->LIWB, other->ERR.
REQ-013 MEMADR (alusrca=1, alusrcb=10) SHALL go to MEMRD for loads, MEMWR for stores.
REQ-014 MEMRD (mem_req=1, iord=1) SHALL go to MEMWB on mem_ready; MEMWB SHALL drive regwrite=1, memtoreg=1, regdst=0, then FETCH.
REQ-015 MEMWR SHALL drive mem_req=1, iord=1, memwrite=mem_ready; go to FETCH on mem_ready.
REQ-016 EXEC (alusrca=1, alusrcb=00, aluop=10) -> ALUWB (regwrite=1, regdst=1) -> FETCH.
REQ-017 BRANCH SHALL drive alusrca=1, aluop=01, pcsrc=01, branch=1, then FETCH.
REQ-018 ADDIEX (alusrca=1, alusrcb=10) -> ADDIWB (regwrite=1, regdst=0) -> FETCH.
REQ-019 JUMP SHALL drive pcsrc=10, pcwrite=1, then FETCH.
REQ-020 LIWB SHALL drive regwrite=1, regdst=0, res_zeroextimm=1, then FETCH.
REQ-021 Every output not listed for a state SHALL be 0.
REQ-022 Zero-wait latency in cycles SHALL be: R 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4, LI 3.
REQ-023 A wait counter SHALL clear on entry to FETCH/MEMRD/MEMWR, increment each cycle mem_ready=0, and force ERR when it reaches WAIT_MAX with mem_ready still 0.
REQ-024 mem_ready in the cycle the counter reaches WAIT_MAX SHALL complete normally (ready wins).
REQ-025 ERR SHALL hold all write enables and mem_req at 0, err=1, until reset.
REQ-026 mem_ready outside FETCH/MEMRD/MEMWR SHALL be ignored.

Reset
REQ-027 reset_n=0 at a clk edge SHALL load FETCH, clear the wait counter and err, regardless of current state or pending memory access.
REQ-028 After reset outputs SHALL equal FETCH values (REQ-011); err=0, state_o=0.

Configuration
REQ-029 Macro MULTICYCLE_CTRL_BYTE_EN defined: DECODE SHALL route 100000 (LB) and 101000 (SB) like LW/SW with byte_enable=1 in MEMADR, MEMRD/MEMWR, MEMWB.
REQ-030 Macro undefined: 100000/101000 SHALL go to ERR and byte_enable SHALL be constant 0.

Structure
REQ-031 Package multicycle_ctrl_pkg SHALL hold the state enum (4-bit, FETCH=0), opcode constants, alusrcb/pcsrc/aluop encodings.
REQ-032 Wait counter SHALL be sub-module mc_wait_timer (clear, tick, expired).

Verification
REQ-033 Reset, op=000000, mem_ready=1 -> states 0,DECODE,EXEC,ALUWB,FETCH; regwrite=1 with regdst=1 only in ALUWB.
REQ-034 op=100011, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with memtoreg=1; total 8 cycles.
REQ-035 WAIT_MAX=4, mem_ready=0 in FETCH -> ERR after 4 cycles, err=1, pcwrite=0; reset_n=0 one edge -> FETCH, err=0.
REQ-036 op=111111 at DECODE -> ERR next cycle; op=010001 -> LIWB with res_zeroextimm=1, 3-cycle instruction.
REQ-037 op=101000 with macro -> MEMWR byte_enable=1, memwrite=1 on mem_ready; without macro -> ERR.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes and mux/ALU selects.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    LIWB   = 4'd12,
    ERR    = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_LI   = 6'b010001;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_SB   = 6'b101000;

  localparam logic [1:0] ALUSRCB_REG   = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_BRIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_wait.sv
// mc_wait_timer: counts consecutive not-ready cycles of one memory state and flags the last allowed one.
module mc_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  logic [7:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      count_q <= 8'd0;
    end else if (tick) begin
      count_q <= count_q + 8'd1;
    end
  end

  // Expiry is judged on the tick that would bring the count to WAIT_MAX.
  assign expired = tick && (count_q == 8'(WAIT_MAX - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle CPU with memory-wait timeout.
// Optional byte load/store (LB/SB) support: define MULTICYCLE_CTRL_BYTE_EN.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int OPW      = 6,
  parameter int WAIT_MAX = 15
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [OPW-1:0] op,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           iord,
  output logic           irwrite,
  output logic           pcwrite,
  output logic           branch,
  output logic           memwrite,
  output logic           regdst,
  output logic           regwrite,
  output logic           memtoreg,
  output logic           alusrca,
  output logic           byte_enable,
  output logic           res_zeroextimm,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic [1:0]     aluop,
  output logic           err,
  output logic [3:0]     state_o
);

  state_t state_q, state_d;
  logic   mem_store_q;
  logic   mem_byte_q;
  logic   wait_state;
  logic   wait_expired;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory direction/size captured at dispatch so later states need not trust op.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_store_q <= 1'b0;
    end else if (state_q == DECODE) begin
`ifdef MULTICYCLE_CTRL_BYTE_EN
      mem_store_q <= (op == OPW'(OP_SW)) || (op == OPW'(OP_SB));
`else
      mem_store_q <= (op == OPW'(OP_SW));
`endif
    end
  end

`ifdef MULTICYCLE_CTRL_BYTE_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_byte_q <= 1'b0;
    end else if (state_q == DECODE) begin
      mem_byte_q <= (op == OPW'(OP_LB)) || (op == OPW'(OP_SB));
    end
  end
`else
  assign mem_byte_q = 1'b0;
`endif

  assign wait_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);

  mc_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_d != state_q),
    .tick    (wait_state && !mem_ready),
    .expired (wait_expired)
  );

  always_comb begin
    state_d        = state_q;
    mem_req        = 1'b0;
    iord           = 1'b0;
    irwrite        = 1'b0;
    pcwrite        = 1'b0;
    branch         = 1'b0;
    memwrite       = 1'b0;
    regdst         = 1'b0;
    regwrite       = 1'b0;
    memtoreg       = 1'b0;
    alusrca        = 1'b0;
    byte_enable    = 1'b0;
    res_zeroextimm = 1'b0;
    alusrcb        = ALUSRCB_REG;
    pcsrc          = PCSRC_ALU;
    aluop          = ALUOP_ADD;
    err            = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        alusrcb = ALUSRCB_FOUR;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready)         state_d = DECODE;
        else if (wait_expired) state_d = ERR;
      end
      DECODE: begin
        alusrcb = ALUSRCB_BRIMM;
        case (op)
          OPW'(OP_R):              state_d = EXEC;
          OPW'(OP_LW), OPW'(OP_SW): state_d = MEMADR;
          OPW'(OP_BEQ):            state_d = BRANCH;
          OPW'(OP_ADDI):           state_d = ADDIEX;
          OPW'(OP_J):              state_d = JUMP;
          OPW'(OP_LI):             state_d = LIWB;
`ifdef MULTICYCLE_CTRL_BYTE_EN
          OPW'(OP_LB), OPW'(OP_SB): state_d = MEMADR;
`else
          OPW'(OP_LB), OPW'(OP_SB): state_d = ERR;
`endif
          default:                 state_d = ERR;
        endcase
      end
      MEMADR: begin
        alusrca     = 1'b1;
        alusrcb     = ALUSRCB_IMM;
        byte_enable = mem_byte_q;
        state_d     = mem_store_q ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req     = 1'b1;
        iord        = 1'b1;
        byte_enable = mem_byte_q;
        if (mem_ready)         state_d = MEMWB;
        else if (wait_expired) state_d = ERR;
      end
      MEMWB: begin
        regwrite    = 1'b1;
        memtoreg    = 1'b1;
        byte_enable = mem_byte_q;
        state_d     = FETCH;
      end
      MEMWR: begin
        mem_req     = 1'b1;
        iord        = 1'b1;
        memwrite    = mem_ready;
        byte_enable = mem_byte_q;
        if (mem_ready)         state_d = FETCH;
        else if (wait_expired) state_d = ERR;
      end
      EXEC: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_REG;
        aluop   = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
        state_d = FETCH;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      JUMP: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
        state_d = FETCH;
      end
      LIWB: begin
        regwrite       = 1'b1;
        res_zeroextimm = 1'b1;
        state_d        = FETCH;
      end
      ERR: begin
        err = 1'b1;
      end
      default: begin
        state_d = ERR;
      end
    endcase
  end

  assign state_o = state_q;

endmodule
